// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC controller.
package sar_adc_pkg;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    localparam int SAR_ADC_DEF_WIDTH = 8;

endpackage

// File: rtl/sar_adc.sv
// SAR ADC controller: one bit per clock, MSB first, against external DAC/comparator.
// Define SAR_ADC_CONT_EN for free-running back-to-back conversions.
module sar_adc
    import sar_adc_pkg::*;
#(
    parameter int ADC_WIDTH = SAR_ADC_DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmp,
    input  logic                 start,
    output logic [ADC_WIDTH-1:0] DACF,
    output logic                 eoc,
    output logic                 den,
    output logic [ADC_WIDTH-1:0] Dout
);

    localparam int IW = $clog2(ADC_WIDTH);
    localparam logic [IW-1:0] TOP = IW'(ADC_WIDTH - 1);
    localparam logic [ADC_WIDTH-1:0] MSB = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    state_t               state;
    state_t               state_nxt;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_nxt;
    logic [ADC_WIDTH-1:0] code;
    logic [ADC_WIDTH-1:0] code_nxt;
    logic [ADC_WIDTH-1:0] result;
    logic [ADC_WIDTH-1:0] result_nxt;
    logic [ADC_WIDTH-1:0] trial;
    logic                 den_q;
    logic                 den_nxt;
    logic                 last;

    assign last = (idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
`ifdef SAR_ADC_CONT_EN
                state_nxt = CONV;
`else
                if (last) begin
                    state_nxt = IDLE;
                end
`endif
            end
        endcase
    end

    // trial is the current code with this cycle's comparator decision applied
    always_comb begin
        trial      = code;
        if (!cmp) begin
            trial[idx] = 1'b0;
        end
        code_nxt   = code;
        idx_nxt    = idx;
        result_nxt = result;
        den_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    code_nxt = MSB;
                    idx_nxt  = TOP;
                end
            end
            CONV: begin
                if (last) begin
                    result_nxt = trial;
                    den_nxt    = 1'b1;
                    idx_nxt    = TOP;
`ifdef SAR_ADC_CONT_EN
                    code_nxt   = MSB;
`else
                    code_nxt   = trial;
`endif
                end else begin
                    code_nxt               = trial;
                    code_nxt[idx - 1'b1]   = 1'b1;
                    idx_nxt                = idx - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code   <= '0;
            result <= '0;
            idx    <= TOP;
            den_q  <= 1'b0;
        end else begin
            code   <= code_nxt;
            result <= result_nxt;
            idx    <= idx_nxt;
            den_q  <= den_nxt;
        end
    end

    assign DACF = code;
    assign Dout = result;
    assign den  = den_q;
    assign eoc  = (state == IDLE);

endmodule

// File: tb/tb_sar_adc.sv
// Self-checking bench for sar_adc: directed and random conversions
// against an arithmetic successive-approximation reference.
module tb_sar_adc;

    localparam int W = 8;
`ifdef SAR_ADC_CONT_EN
    localparam int PERIOD = W;
    localparam int EOC_HI = 0;
`else
    localparam int PERIOD = W + 1;
    localparam int EOC_HI = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cmp;
    logic         start;
    logic [W-1:0] dacf;
    logic         eoc;
    logic         den;
    logic [W-1:0] dout;

    logic         use_model;
    logic [W-1:0] vin;
    logic         pat_cmp;

    int vectors     = 0;
    int miscompares = 0;
    int den_count   = 0;

    sar_adc #(.ADC_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmp   (cmp),
        .start (start),
        .DACF  (dacf),
        .eoc   (eoc),
        .den   (den),
        .Dout  (dout)
    );

    always #5 clk = ~clk;

    // analog comparator: input voltage vs DAC output, or a scripted bit pattern
    always_comb cmp = use_model ? (vin >= dacf) : pat_cmp;

    always @(posedge clk) if (den) den_count++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full conversion; expected trial codes follow from the bits decided so far.
    task automatic convert(input bit model, input logic [W-1:0] v,
                           input logic [W-1:0] pat, input bit inject);
        logic [W-1:0] decided;
        logic [W-1:0] trial;
        bit           b;
        use_model = model;
        vin       = v;
        pat_cmp   = pat[W-1];
        decided   = '0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_dacf", dacf, 32'(1 << (W-1)));
        check("start_eoc", eoc, 0);
        check("start_den", den, 0);
        for (int k = W-1; k >= 0; k--) begin
            pat_cmp = pat[k];
            if (inject && k == W-3) start = 1'b1;
            trial = decided | (W'(1) << k);
            b     = model ? (v >= trial) : pat[k];
            @(posedge clk); #1;
            start = 1'b0;
            if (b) decided = trial;
            if (k > 0) begin
                check("step_dacf", dacf, decided | (W'(1) << (k-1)));
                check("step_eoc", eoc, 0);
                check("step_den", den, 0);
            end else begin
                check("done_den", den, 1);
                check("done_eoc", eoc, 1);
                check("done_dout", dout, decided);
                check("done_dacf", dacf, decided);
            end
        end
        @(posedge clk); #1;
        check("post_den", den, 0);
        check("post_eoc", eoc, 1);
        check("post_dout", dout, decided);
        check("post_dacf", dacf, decided);
        if (model) check("dout_vs_vin", dout, v);
    endtask

    initial begin
        int d0;
        int n;
        int eoc_hi;
        int t [3];
        logic [W-1:0] r;

        rst       = 1'b1;
        start     = 1'b0;
        use_model = 1'b0;
        pat_cmp   = 1'b0;
        vin       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dacf", dacf, 0);
        check("rst_dout", dout, 0);
        check("rst_eoc", eoc, 1);
        check("rst_den", den, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        convert(1'b0, '0, 8'hFF, 1'b0);
        convert(1'b0, '0, 8'h00, 1'b0);
        convert(1'b1, 8'h5A, '0, 1'b0);

        d0 = den_count;
        convert(1'b0, '0, 8'hAA, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        convert(1'b0, '0, 8'hAA, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("toggle_den_cnt", den_count - d0, 2);
        check("toggle_idle_eoc", eoc, 1);

        convert(1'b1, 8'h00, '0, 1'b0);
        convert(1'b1, 8'hFF, '0, 1'b0);
        repeat (8) begin
            r = W'($urandom_range(0, (1 << W) - 1));
            convert(1'b1, r, '0, 1'b0);
        end

        // abort a conversion on its 4th bit cycle
        use_model = 1'b1;
        vin       = 8'h77;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d0    = den_count;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_dacf", dacf, 0);
        check("abort_dout", dout, 0);
        check("abort_eoc", eoc, 1);
        check("abort_den", den, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_den", den_count - d0, 0);
        check("abort_idle_eoc", eoc, 1);
        convert(1'b1, 8'hC3, '0, 1'b0);

        // start held high: measure den spacing and idle gap
        use_model = 1'b0;
        pat_cmp   = 1'b1;
        start     = 1'b1;
        n         = 0;
        eoc_hi    = 0;
        t         = '{0, 0, 0};
        for (int c = 0; c < 80 && n < 3; c++) begin
            @(posedge clk); #1;
            if (den) begin
                t[n] = c;
                n++;
                check("held_dout", dout, 8'hFF);
            end
            if (n == 1 && eoc) eoc_hi++;
        end
        start = 1'b0;
        check("held_den_seen", n, 3);
        check("held_period_a", t[1] - t[0], PERIOD);
        check("held_period_b", t[2] - t[1], PERIOD);
        check("held_eoc_gap", eoc_hi, EOC_HI);

        repeat (12) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
